// File: rtl/boot_sel_fsm_pkg.sv
// Shared definitions for the boot-image selector: state encodings and a
// small helper used to size the shared dwell counter.
package boot_sel_fsm_pkg;

    // State encodings, fixed so debug tooling can decode the state port.
    localparam logic [2:0] ST_START = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_SEL   = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_REARM = 3'd4;
    localparam logic [2:0] ST_LOCK  = 3'd5;
    localparam logic [2:0] ST_BOOT  = 3'd6;

    // Largest of the three dwell limits; the shared counter must reach it.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/boot_sel_fsm.sv
// Boot-image selector: short presses step through the images, an idle
// timeout or a long press commits, an optional flash-lock handshake runs,
// then a sticky warm-boot request is raised. All outputs are registered.
module boot_sel_fsm
    import boot_sel_fsm_pkg::*;
#(
    parameter int N_IMAGES      = 4,
    parameter int DEFAULT_IMG   = 2,
    parameter int SEL_INIT_IMG  = 1,
    parameter int LOCK_SKIP_IMG = 0,
    parameter int LOCK_EN       = 1,
    parameter int LONG_EN       = 1,
    parameter int TMO_CYC       = 2**23,
    parameter int REARM_CYC     = 2**15,
    parameter int LONG_CYC      = 2**22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_v,
    input  logic       btn_r,
    input  logic       btn_f,
    input  logic       fl_rdy,
    output logic       fl_go,
    output logic [1:0] boot_sel,
    output logic       boot_now,
    output logic       selecting,
    output logic [2:0] state
);

    localparam int CNT_W = $clog2(max3(TMO_CYC, REARM_CYC, LONG_CYC));

    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] REARM_LAST = CNT_W'(REARM_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYC - 1);

    localparam logic [1:0] IMG_DEFAULT = 2'(DEFAULT_IMG);
    localparam logic [1:0] IMG_INIT    = 2'(SEL_INIT_IMG);
    localparam logic [1:0] IMG_SKIP    = 2'(LOCK_SKIP_IMG);
    localparam logic [1:0] IMG_LAST    = 2'(N_IMAGES - 1);

    logic [CNT_W-1:0] cnt;
    logic             skip;
    logic             term;
    logic [2:0]       commit_st;
    logic [2:0]       state_nxt;
    logic [1:0]       sel_nxt;
    logic             skip_nxt;

    // Terminal count for whichever dwell limit applies in the current state.
    always_comb begin
        term = 1'b0;
        case (state)
            ST_SEL:   term = (cnt == TMO_LAST);
            ST_HOLD:  term = (cnt == LONG_LAST);
            ST_REARM: term = (cnt == REARM_LAST);
            default:  term = 1'b0;
        endcase
    end

    // Commit decode: lock the flash first unless disabled or skipped.
    always_comb begin
        commit_st = ((LOCK_EN != 0) && !skip) ? ST_LOCK : ST_BOOT;
    end

    // Next-state, next-image and skip-flag decode.
    always_comb begin
        state_nxt = state;
        sel_nxt   = boot_sel;
        skip_nxt  = skip;
        case (state)
            ST_START: state_nxt = btn_v ? ST_BOOT : ST_WAIT;
            ST_WAIT: begin
                if (btn_v) begin
                    sel_nxt   = IMG_INIT;
                    state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                // A press on the timeout cycle takes priority over committing.
                if (btn_f)     state_nxt = ST_HOLD;
                else if (term) state_nxt = commit_st;
            end
            ST_HOLD: begin
                // A long press reaching its limit wins over a same-cycle release.
                if ((LONG_EN != 0) && term) begin
                    state_nxt = commit_st;
                end else if (btn_r) begin
                    sel_nxt   = (boot_sel == IMG_LAST) ? 2'd0 : boot_sel + 2'd1;
                    if (boot_sel == IMG_SKIP) skip_nxt = 1'b1;
                    state_nxt = ST_REARM;
                end
            end
            ST_REARM: begin
                if (term) state_nxt = ST_SEL;
            end
            ST_LOCK: begin
                // fl_go is high only on the first LOCK cycle, so ready is
                // honoured from the second cycle onward.
                if (!fl_go && fl_rdy) state_nxt = ST_BOOT;
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // State, counter, selection and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_START;
            cnt       <= '0;
            boot_sel  <= IMG_DEFAULT;
            skip      <= 1'b0;
            fl_go     <= 1'b0;
            boot_now  <= 1'b0;
            selecting <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state_nxt != state) ? '0 : cnt + 1'b1;
            boot_sel  <= sel_nxt;
            skip      <= skip_nxt;
            fl_go     <= (state_nxt == ST_LOCK) && (state != ST_LOCK);
            boot_now  <= boot_now | (state == ST_BOOT);
            selecting <= (state_nxt == ST_SEL) || (state_nxt == ST_HOLD) ||
                         (state_nxt == ST_REARM);
        end
    end

endmodule

// File: tb/tb_boot_sel_fsm.sv
// Testbench for boot_sel_fsm: directed scenarios plus randomized button
// activity, every cycle compared against a behavioural mode/age model.
module tb_boot_sel_fsm;

    localparam int N_IMG = 4;
    localparam int DEF   = 2;
    localparam int INIT  = 1;
    localparam int SKIPI = 0;
    localparam int TMO   = 100;
    localparam int RARM  = 10;
    localparam int LONG  = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_v, btn_r, btn_f, fl_rdy;
    logic       fl_go, boot_now, selecting;
    logic [1:0] boot_sel;
    logic [2:0] state;

    boot_sel_fsm #(
        .N_IMAGES(N_IMG), .DEFAULT_IMG(DEF), .SEL_INIT_IMG(INIT),
        .LOCK_SKIP_IMG(SKIPI), .LOCK_EN(1), .LONG_EN(1),
        .TMO_CYC(TMO), .REARM_CYC(RARM), .LONG_CYC(LONG)
    ) dut (
        .clk(clk), .rst(rst), .btn_v(btn_v), .btn_r(btn_r), .btn_f(btn_f),
        .fl_rdy(fl_rdy), .fl_go(fl_go), .boot_sel(boot_sel),
        .boot_now(boot_now), .selecting(selecting), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: which mode we are in and how long we've been there.
    typedef enum int {M_BOOT, M_LOCK, M_SEL, M_HOLD, M_REARM, M_WAIT, M_START} mmode_t;
    mmode_t m_mode;
    int     m_age;
    int     m_img;
    bit     m_skip;

    bit btn_prev;
    bit armed;
    int go_cnt;
    int go_seen;

    task automatic check(input string tag, input logic [31:0] got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned code_of(input mmode_t m);
        case (m)
            M_START: return 0;
            M_WAIT:  return 1;
            M_SEL:   return 2;
            M_HOLD:  return 3;
            M_REARM: return 4;
            M_LOCK:  return 5;
            default: return 6;
        endcase
    endfunction

    function automatic bit exp_go();
        return (m_mode == M_LOCK) && (m_age == 0);
    endfunction

    task automatic model_reset();
        m_mode = M_START; m_age = 0; m_img = DEF; m_skip = 0;
    endtask

    task automatic model_step(input bit v, input bit r, input bit f, input bit rdy);
        mmode_t nx;
        mmode_t done_to;
        nx = m_mode;
        done_to = m_skip ? M_BOOT : M_LOCK;
        case (m_mode)
            M_START: nx = v ? M_BOOT : M_WAIT;
            M_WAIT:  if (v) begin nx = M_SEL; m_img = INIT; end
            M_SEL: begin
                if (f) nx = M_HOLD;
                else if (m_age + 1 == TMO) nx = done_to;
            end
            M_HOLD: begin
                if (m_age + 1 == LONG) nx = done_to;
                else if (r) begin
                    if (m_img == SKIPI) m_skip = 1;
                    m_img = (m_img + 1) % N_IMG;
                    nx = M_REARM;
                end
            end
            M_REARM: if (m_age + 1 == RARM) nx = M_SEL;
            M_LOCK:  if (m_age >= 1 && rdy) nx = M_BOOT;
            default: nx = M_BOOT;
        endcase
        m_age  = (nx != m_mode) ? 0 : m_age + 1;
        m_mode = nx;
    endtask

    task automatic cmp_all();
        check("state", state, code_of(m_mode));
        check("boot_sel", boot_sel, m_img);
        check("boot_now", boot_now, (m_mode == M_BOOT && m_age >= 1) ? 1 : 0);
        check("fl_go", fl_go, exp_go() ? 1 : 0);
        check("selecting", selecting,
              (m_mode == M_SEL || m_mode == M_HOLD || m_mode == M_REARM) ? 1 : 0);
    endtask

    // One clock cycle with button level lvl; strobes derive from level changes.
    task automatic cyc(input bit lvl);
        btn_f    = btn_prev & ~lvl;
        btn_r    = ~btn_prev & lvl;
        btn_v    = lvl;
        btn_prev = lvl;
        fl_rdy   = armed && (go_cnt >= 19);
        @(posedge clk);
        model_step(btn_v, btn_r, btn_f, fl_rdy);
        #1;
        cmp_all();
        if (fl_go === 1'b1) go_seen++;
        if (exp_go()) begin armed = 1; go_cnt = 0; end
        else if (armed) go_cnt++;
    endtask

    task automatic do_reset(input bit lvl);
        rst = 1'b1;
        btn_v = lvl; btn_prev = lvl; btn_r = 1'b0; btn_f = 1'b0; fl_rdy = 1'b0;
        armed = 0; go_cnt = 0; go_seen = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        cmp_all();
        rst = 1'b0;
    endtask

    task automatic enter_sel();
        do_reset(1'b0);
        cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic short_press();
        repeat (5) cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic wait_boot(input string tag);
        for (int i = 0; i < 300 && boot_now !== 1'b1; i++) cyc(1'b1);
        check(tag, boot_now, 1);
    endtask

    int exp_seq[3] = '{2, 3, 0};

    initial begin
        // 1: released at reset release boots the default image immediately.
        do_reset(1'b1);
        check("t1_rst_sel", boot_sel, DEF);
        cyc(1'b1);
        check("t1_edge1_now", boot_now, 0);
        cyc(1'b1);
        check("t1_edge2_now", boot_now, 1);
        check("t1_sel", boot_sel, 2);
        repeat (5) cyc(1'b1);
        check("t1_no_go", go_seen, 0);

        // 2: three short presses 1->2->3->0, then timeout, lock, boot.
        enter_sel();
        check("t2_init_sel", boot_sel, 1);
        for (int k = 0; k < 3; k++) begin
            short_press();
            check("t2_step", boot_sel, exp_seq[k]);
            repeat (12) cyc(1'b1);
        end
        wait_boot("t2_boot");
        check("t2_go_once", go_seen, 1);
        check("t2_final_sel", boot_sel, 0);

        // 3: press while image 0 selected sets skip; commit skips the lock.
        enter_sel();
        for (int k = 0; k < 3; k++) begin short_press(); repeat (12) cyc(1'b1); end
        short_press();
        check("t3_sel", boot_sel, 1);
        wait_boot("t3_boot");
        check("t3_no_go", go_seen, 0);
        check("t3_final_sel", boot_sel, 1);

        // 4: long press commits on HOLD cycle 50 into LOCK.
        enter_sel();
        repeat (51) cyc(1'b0);
        check("t4_lock", state, 5);
        check("t4_go", fl_go, 1);
        check("t4_sel", boot_sel, 1);
        repeat (9) cyc(1'b0);
        wait_boot("t4_boot");
        check("t4_final_sel", boot_sel, 1);

        // 5: press on the timeout cycle wins; REARM ignores presses.
        enter_sel();
        repeat (99) cyc(1'b1);
        cyc(1'b0);
        check("t5_hold", state, 3);
        repeat (3) cyc(1'b0);
        cyc(1'b1);
        check("t5_inc", boot_sel, 2);
        check("t5_rearm", state, 4);
        repeat (3) cyc(1'b0);
        repeat (3) cyc(1'b1);
        check("t5_rearm_still", state, 4);
        repeat (4) cyc(1'b1);
        check("t5_back_sel", state, 2);
        check("t5_sel_kept", boot_sel, 2);
        check("t5_no_go", go_seen, 0);

        // 6: asynchronous reset on LOCK cycle 5.
        enter_sel();
        repeat (51) cyc(1'b0);
        repeat (4) cyc(1'b0);
        check("t6_in_lock", state, 5);
        rst = 1'b1;
        #2;
        check("t6_state", state, 0);
        check("t6_sel", boot_sel, 2);
        check("t6_now", boot_now, 0);
        check("t6_go", fl_go, 0);
        model_reset();

        // Randomized button activity.
        for (int ep = 0; ep < 8; ep++) begin
            bit lvl;
            int dur;
            bit done;
            lvl = ($urandom_range(0, 3) == 0);
            do_reset(lvl);
            dur = $urandom_range(1, 8);
            done = 0;
            for (int i = 0; i < 3000 && !done; i++) begin
                if (dur == 0) begin
                    lvl = ~lvl;
                    if (lvl) dur = $urandom_range(1, 130);
                    else dur = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 15)
                                                          : $urandom_range(40, 70);
                end else begin
                    dur--;
                end
                cyc(lvl);
                if (m_mode == M_BOOT && m_age > 5) done = 1;
            end
            check("ep_boot", boot_now, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
